// File: rtl/seq_sign_mult_if.sv
// Handshake and operand/result bundle between the ALU control and the sequential
// signed multiplier.
interface seq_sign_mult_if #(
  parameter int BITS = 4
);
  logic                Start;
  logic [BITS-1:0]     A_Plus;
  logic                A_Neg;
  logic                A_Zero;
  logic [BITS-1:0]     B_Plus;
  logic                B_Neg;
  logic                B_Zero;
  logic                Busy;
  logic                Done;
  logic [2*BITS-1:0]   Product;
  logic                P_Neg;

  modport master (
    output Start, A_Plus, A_Neg, A_Zero, B_Plus, B_Neg, B_Zero,
    input  Busy, Done, Product, P_Neg
  );

  modport slave (
    input  Start, A_Plus, A_Neg, A_Zero, B_Plus, B_Neg, B_Zero,
    output Busy, Done, Product, P_Neg
  );
endinterface

// File: rtl/seq_sign_mult.sv
// Sequential sign/magnitude multiplier: BITS-cycle shift-add on the magnitudes,
// then one cycle to apply the product sign. Start/Busy/Done handshake.
module seq_sign_mult #(
  parameter int BITS = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  seq_sign_mult_if.slave  bus
);
  localparam int PW = 2 * BITS;
  localparam int CW = $clog2(BITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(BITS - 1);
  localparam logic [PW-1:0] ONE_P    = PW'(1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_NEG  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q,   state_d;
  logic [PW-1:0]   acc_q,     acc_d;
  logic [PW-1:0]   mcand_q,   mcand_d;
  logic [BITS-1:0] mplier_q,  mplier_d;
  logic [CW-1:0]   count_q,   count_d;
  logic            sign_q,    sign_d;
  logic            busy_q,    busy_d;
  logic            done_q,    done_d;
  logic [PW-1:0]   product_q, product_d;
  logic            p_neg_q,   p_neg_d;

  // Next-state and datapath: Busy/Done are computed from the next state so they are registered.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    sign_d    = sign_q;
    product_d = product_q;
    p_neg_d   = p_neg_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.Start) begin
          mcand_d  = {{BITS{1'b0}}, bus.A_Plus};
          mplier_d = bus.B_Plus;
          sign_d   = bus.A_Neg ^ bus.B_Neg;
          acc_d    = '0;
          count_d  = '0;
          if (bus.A_Zero | bus.B_Zero) begin
            state_d   = S_DONE;
            product_d = '0;
            p_neg_d   = 1'b0;
            done_d    = 1'b1;
          end else begin
            state_d = S_CALC;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end else begin
          acc_d = acc_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + ONE_C;
        busy_d   = 1'b1;
        if (count_q == LAST_CNT) begin
          state_d = S_NEG;
        end else begin
          state_d = S_CALC;
        end
      end
      S_NEG: begin
        // Magnitude is never zero here, so the latched sign is the product sign.
        if (sign_q) begin
          product_d = ~acc_q + ONE_P;
        end else begin
          product_d = acc_q;
        end
        p_neg_d = sign_q;
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      sign_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      p_neg_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      sign_q    <= sign_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
      p_neg_q   <= p_neg_d;
    end
  end

  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.Product = product_q;
  assign bus.P_Neg   = p_neg_q;
endmodule
